// File: rtl/tdm_demux4_4bits_pkg.sv
// rtl/tdm_demux4_4bits_pkg.sv - shared state encoding and slot constants for the TDM receiver
package tdm_demux4_4bits_pkg;

  // HUNT: waiting for a frame_sync beat; RECV: locked onto the frame
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_demux4_4bits_if.sv
// rtl/tdm_demux4_4bits_if.sv - link-side inputs and channel-side outputs of the TDM receiver
interface tdm_demux4_4bits_if #(
  parameter int P_WIDTH = 4
);
  logic [P_WIDTH-1:0] din;
  logic               din_valid;
  logic               frame_sync;
  logic [P_WIDTH-1:0] sai0;
  logic [P_WIDTH-1:0] sai1;
  logic [P_WIDTH-1:0] sai2;
  logic [P_WIDTH-1:0] sai3;
  logic               frame_valid;
  logic [1:0]         slot;
  logic               sync_err;

  // Link driver side
  modport master (
    output din, din_valid, frame_sync,
    input  sai0, sai1, sai2, sai3, frame_valid, slot, sync_err
  );

  // Receiver side
  modport slave (
    input  din, din_valid, frame_sync,
    output sai0, sai1, sai2, sai3, frame_valid, slot, sync_err
  );
endinterface

// File: rtl/tdm_demux4_4bits_decod_2x4.sv
// rtl/tdm_demux4_4bits_decod_2x4.sv - slot number to one-hot write strobe, inverse of the link selector
module tdm_demux4_4bits_decod_2x4
  import tdm_demux4_4bits_pkg::*;
(
  input  logic [1:0] slot_i,
  input  logic       en_i,
  output logic [3:0] we_o
);

  // One strobe per slot, all low when no beat is being stored
  always_comb begin
    we_o = 4'b0000;
    if (en_i) begin
      case (slot_i)
        SLOT0:   we_o = 4'b0001;
        SLOT1:   we_o = 4'b0010;
        SLOT2:   we_o = 4'b0100;
        SLOT3:   we_o = 4'b1000;
        default: we_o = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux4_4bits.sv
// rtl/tdm_demux4_4bits.sv - 4-channel TDM receiver rebuilding frame-coherent channel outputs
module tdm_demux4_4bits
  import tdm_demux4_4bits_pkg::*;
#(
  parameter int P_WIDTH       = 4,
  parameter int P_TIMEOUT     = 16,
  parameter bit P_STRICT_SYNC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdm_demux4_4bits_if.slave    bus
);

  localparam int CW = $clog2(P_TIMEOUT + 1);

  state_e             state_q;
  logic [1:0]         slot_q;
  logic [CW-1:0]      idle_q;
  logic [P_WIDTH-1:0] shadow_q [3];
  logic [P_WIDTH-1:0] sai_q    [4];
  logic               frame_valid_q;
  logic               sync_err_q;

  logic               beat;
  logic               strict_drop;
  logic               resync;
  logic               wr_en;
  logic [1:0]         wr_slot;
  logic [3:0]         we;
  logic [CW-1:0]      idle_inc;
  logic               timeout_hit;

  // Classify the current beat and decide where (if anywhere) it is stored
  always_comb begin
    beat        = bus.din_valid;
    strict_drop = P_STRICT_SYNC && (state_q == ST_RECV) && beat &&
                  !bus.frame_sync && (slot_q == SLOT0);
    resync      = (state_q == ST_RECV) && beat && bus.frame_sync && (slot_q != SLOT0);
    if (state_q == ST_HUNT) begin
      wr_en = beat && bus.frame_sync;
    end else begin
      wr_en = beat && !strict_drop;
    end
    // A sync beat always restarts at slot 0, so a sync at slot 3 never completes a frame
    wr_slot     = (bus.frame_sync || (state_q == ST_HUNT)) ? SLOT0 : slot_q;
    idle_inc    = (idle_q == CW'(P_TIMEOUT)) ? idle_q : idle_q + 1'b1;
    timeout_hit = (state_q == ST_RECV) && !beat && (slot_q != SLOT0) &&
                  (idle_inc == CW'(P_TIMEOUT));
  end

  // A store into slot 3 is exactly the frame-completing beat
  tdm_demux4_4bits_decod_2x4 u_decod (
    .slot_i (wr_slot),
    .en_i   (wr_en),
    .we_o   (we)
  );

  // Shadow registers collect slots 0..2 of the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (we[i]) shadow_q[i] <= bus.din;
      end
    end
  end

  // Frame FSM: slot/idle tracking, pulse generation and output publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      slot_q        <= SLOT0;
      idle_q        <= '0;
      sai_q         <= '{default: '0};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= we[3];
      sync_err_q    <= resync || strict_drop || timeout_hit;

      if (we[3]) begin
        sai_q[0] <= shadow_q[0];
        sai_q[1] <= shadow_q[1];
        sai_q[2] <= shadow_q[2];
        sai_q[3] <= bus.din;
      end

      if (beat || timeout_hit || (state_q == ST_HUNT) || (slot_q == SLOT0)) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_inc;
      end

      if (wr_en) begin
        slot_q <= wr_slot + 2'd1;
      end else if (timeout_hit) begin
        slot_q <= SLOT0;
      end

      if (strict_drop || timeout_hit) begin
        state_q <= ST_HUNT;
      end else if (wr_en) begin
        state_q <= ST_RECV;
      end
    end
  end

  assign bus.sai0        = sai_q[0];
  assign bus.sai1        = sai_q[1];
  assign bus.sai2        = sai_q[2];
  assign bus.sai3        = sai_q[3];
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot        = slot_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4_4bits.sv
// tb/tb_tdm_demux4_4bits.sv - directed-vector bench for strict and lenient receivers
module tb_tdm_demux4_4bits;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  tdm_demux4_4bits_if bus_s ();
  tdm_demux4_4bits_if bus_n ();

  tdm_demux4_4bits #(.P_WIDTH(4), .P_TIMEOUT(16), .P_STRICT_SYNC(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  tdm_demux4_4bits #(.P_WIDTH(4), .P_TIMEOUT(16), .P_STRICT_SYNC(1'b0)) u_dut_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  logic [15:0] sai_s;
  logic [15:0] sai_n;
  assign sai_s = {bus_s.sai0, bus_s.sai1, bus_s.sai2, bus_s.sai3};
  assign sai_n = {bus_n.sai0, bus_n.sai1, bus_n.sai2, bus_n.sai3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] d, input logic s);
    bus_s.din_valid = v; bus_s.din = d; bus_s.frame_sync = s;
    bus_n.din_valid = v; bus_n.din = d; bus_n.frame_sync = s;
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic s);
    drive(v, d, s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'h5, 1'b1);
    n_vec++; if (sai_s !== 16'h0000) begin n_err++; $display("FAIL reset_sai: got %h want %h", sai_s, 16'h0000); end
    n_vec++; if ({bus_s.frame_valid, bus_s.sync_err} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want %b", {bus_s.frame_valid, bus_s.sync_err}, 2'b00); end
    n_vec++; if (bus_s.slot !== 2'd0) begin n_err++; $display("FAIL reset_slot: got %0d want %0d", bus_s.slot, 0); end
    drive(1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_frame;
    cycle(1'b1, 4'hA, 1'b1);
    cycle(1'b1, 4'h3, 1'b0);
    cycle(1'b1, 4'h7, 1'b0);
    n_vec++; if ({bus_s.frame_valid, bus_s.slot} !== 3'b0_11) begin n_err++; $display("FAIL frame_mid: got %b want %b", {bus_s.frame_valid, bus_s.slot}, 3'b0_11); end
    cycle(1'b1, 4'hF, 1'b0);
    n_vec++; if (sai_s !== 16'hA37F) begin n_err++; $display("FAIL frame_sai: got %h want %h", sai_s, 16'hA37F); end
    n_vec++; if ({bus_s.frame_valid, bus_s.sync_err, bus_s.slot} !== 4'b1_0_00) begin n_err++; $display("FAIL frame_flags: got %b want %b", {bus_s.frame_valid, bus_s.sync_err, bus_s.slot}, 4'b1_0_00); end
    cycle(1'b0, 4'h0, 1'b0);
    n_vec++; if ({bus_s.frame_valid, sai_s} !== {1'b0, 16'hA37F}) begin n_err++; $display("FAIL frame_pulse_end: got %h want %h", {bus_s.frame_valid, sai_s}, {1'b0, 16'hA37F}); end
  endtask

  task automatic test_resync;
    cycle(1'b1, 4'h1, 1'b1);
    cycle(1'b1, 4'h2, 1'b0);
    cycle(1'b1, 4'h3, 1'b0);
    cycle(1'b1, 4'h9, 1'b1);
    n_vec++; if ({bus_s.sync_err, bus_s.frame_valid, bus_s.slot} !== 4'b1_0_01) begin n_err++; $display("FAIL resync_flags: got %b want %b", {bus_s.sync_err, bus_s.frame_valid, bus_s.slot}, 4'b1_0_01); end
    n_vec++; if (sai_s !== 16'hA37F) begin n_err++; $display("FAIL resync_hold: got %h want %h", sai_s, 16'hA37F); end
    cycle(1'b0, 4'h0, 1'b0);
    n_vec++; if (bus_s.sync_err !== 1'b0) begin n_err++; $display("FAIL resync_pulse_end: got %b want %b", bus_s.sync_err, 1'b0); end
    cycle(1'b1, 4'h5, 1'b0);
    cycle(1'b1, 4'h6, 1'b0);
    cycle(1'b1, 4'h7, 1'b0);
    n_vec++; if ({bus_s.frame_valid, sai_s} !== {1'b1, 16'h9567}) begin n_err++; $display("FAIL resync_frame: got %h want %h", {bus_s.frame_valid, sai_s}, {1'b1, 16'h9567}); end
  endtask

  task automatic test_strict;
    cycle(1'b1, 4'h1, 1'b1);
    cycle(1'b1, 4'h2, 1'b0);
    cycle(1'b1, 4'h3, 1'b0);
    cycle(1'b1, 4'h4, 1'b0);
    n_vec++; if (sai_s !== 16'h1234) begin n_err++; $display("FAIL strict_frame: got %h want %h", sai_s, 16'h1234); end
    cycle(1'b1, 4'h8, 1'b0);
    n_vec++; if ({bus_s.sync_err, bus_s.slot, sai_s} !== {1'b1, 2'd0, 16'h1234}) begin n_err++; $display("FAIL strict_err: got %h want %h", {bus_s.sync_err, bus_s.slot, sai_s}, {1'b1, 2'd0, 16'h1234}); end
    n_vec++; if ({bus_n.sync_err, bus_n.slot} !== {1'b0, 2'd1}) begin n_err++; $display("FAIL lenient_accept: got %b want %b", {bus_n.sync_err, bus_n.slot}, {1'b0, 2'd1}); end
    cycle(1'b1, 4'hC, 1'b0);
    n_vec++; if ({bus_s.sync_err, bus_s.slot} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL strict_hunt_drop: got %b want %b", {bus_s.sync_err, bus_s.slot}, {1'b0, 2'd0}); end
    cycle(1'b1, 4'hD, 1'b0);
    cycle(1'b1, 4'hE, 1'b0);
    n_vec++; if ({bus_n.frame_valid, sai_n} !== {1'b1, 16'h8CDE}) begin n_err++; $display("FAIL lenient_frame: got %h want %h", {bus_n.frame_valid, sai_n}, {1'b1, 16'h8CDE}); end
    n_vec++; if ({bus_s.frame_valid, sai_s} !== {1'b0, 16'h1234}) begin n_err++; $display("FAIL strict_hold: got %h want %h", {bus_s.frame_valid, sai_s}, {1'b0, 16'h1234}); end
  endtask

  task automatic test_timeout;
    logic       exp_err;
    logic [1:0] exp_slot;
    cycle(1'b1, 4'h1, 1'b1);
    cycle(1'b1, 4'h2, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 4'h0, 1'b0);
      exp_err  = (i == 16);
      exp_slot = (i == 16) ? 2'd0 : 2'd2;
      n_vec++; if ({bus_s.sync_err, bus_s.slot} !== {exp_err, exp_slot}) begin n_err++; $display("FAIL timeout_idle%0d: got %b want %b", i, {bus_s.sync_err, bus_s.slot}, {exp_err, exp_slot}); end
    end
    cycle(1'b1, 4'h6, 1'b0);
    n_vec++; if ({bus_s.sync_err, bus_s.slot, bus_n.slot} !== 5'b0_00_00) begin n_err++; $display("FAIL timeout_ignore: got %b want %b", {bus_s.sync_err, bus_s.slot, bus_n.slot}, 5'b0_00_00); end
    n_vec++; if (sai_s !== 16'h1234) begin n_err++; $display("FAIL timeout_hold: got %h want %h", sai_s, 16'h1234); end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, 4'h1, 1'b1);
    cycle(1'b1, 4'h2, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({sai_s, sai_n} !== 32'h0) begin n_err++; $display("FAIL areset_sai: got %h want %h", {sai_s, sai_n}, 32'h0); end
    n_vec++; if ({bus_s.slot, bus_s.frame_valid, bus_s.sync_err} !== 4'b0) begin n_err++; $display("FAIL areset_flags: got %b want %b", {bus_s.slot, bus_s.frame_valid, bus_s.sync_err}, 4'b0); end
    drive(1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 4'h5, 1'b1);
    cycle(1'b1, 4'h6, 1'b0);
    cycle(1'b1, 4'h7, 1'b0);
    cycle(1'b1, 4'h8, 1'b0);
    n_vec++; if ({bus_s.frame_valid, sai_s} !== {1'b1, 16'h5678}) begin n_err++; $display("FAIL areset_frame: got %h want %h", {bus_s.frame_valid, sai_s}, {1'b1, 16'h5678}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] d_tab [8];
    logic       fv_exp;
    d_tab = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, d_tab[i], (i % 4) == 0);
      fv_exp = (i == 3) || (i == 7);
      n_vec++; if ({bus_s.frame_valid, bus_s.sync_err} !== {fv_exp, 1'b0}) begin n_err++; $display("FAIL b2b_pulse%0d: got %b want %b", i, {bus_s.frame_valid, bus_s.sync_err}, {fv_exp, 1'b0}); end
      if (i == 3) begin
        n_vec++; if (sai_s !== 16'hABCD) begin n_err++; $display("FAIL b2b_first: got %h want %h", sai_s, 16'hABCD); end
      end
      if (i == 7) begin
        n_vec++; if (sai_s !== 16'h1234) begin n_err++; $display("FAIL b2b_second: got %h want %h", sai_s, 16'h1234); end
      end
    end
    cycle(1'b0, 4'h0, 1'b0);
    n_vec++; if ({bus_s.frame_valid, sai_s} !== {1'b0, 16'h1234}) begin n_err++; $display("FAIL b2b_hold: got %h want %h", {bus_s.frame_valid, sai_s}, {1'b0, 16'h1234}); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    test_reset();
    test_frame();
    test_resync();
    test_strict();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
